// File: rtl/centroid_accumulator.sv
// Per-cluster sum/count accumulator that flushes each cluster as FP16 operands to a divider.
// Build option: define CONV_ROUND_EN for round-half-up FP16 conversion (default truncates).
module centroid_accumulator #(
  parameter int unsigned K  = 4,
  parameter int unsigned LW = 2,
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 8,
  parameter int unsigned SW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pt_valid,
  output logic          pt_ready,
  input  logic [DW-1:0] pt_data,
  input  logic [LW-1:0] pt_label,
  input  logic          pass_end,
  output logic          div_en,
  output logic [15:0]   div_in1,
  output logic [15:0]   div_in2,
  input  logic          div_done,
  output logic [LW-1:0] cl_idx,
  output logic          busy,
  output logic          flush_done
);

  typedef enum logic [1:0] {StAcc, StConv, StIssue, StNext} state_e;

  state_e        state_q;
  logic [SW-1:0] sum_q [K];
  logic [CW-1:0] cnt_q [K];

  logic [SW:0]   sum_add;
  logic [SW-1:0] sum_sat;
  logic          cnt_full;

  // Leading-one normalisation; exponent bias folds in as p + 15.
  function automatic logic [15:0] to_fp16(input logic [15:0] v);
    logic [3:0]  p;
    logic [15:0] norm;
    logic [10:0] mant;
    logic [4:0]  expo;
    p = '0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) p = 4'(i);
    end
    norm = v << (4'd15 - p);
    mant = {1'b0, norm[14:5]};
    expo = 5'(p) + 5'd15;
`ifdef CONV_ROUND_EN
    mant = mant + 11'(norm[4]);
    if (mant[10]) begin
      mant = '0;
      expo = expo + 5'd1;
    end
`endif
    return (v == 16'h0000) ? 16'h0000 : {1'b0, expo, mant[9:0]};
  endfunction

  always_comb begin
    sum_add  = {1'b0, sum_q[pt_label]} + (SW+1)'(pt_data);
    sum_sat  = sum_add[SW] ? '1 : sum_add[SW-1:0];
    cnt_full = &cnt_q[pt_label];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StAcc;
      pt_ready   <= 1'b1;
      busy       <= 1'b0;
      div_en     <= 1'b0;
      div_in1    <= '0;
      div_in2    <= '0;
      cl_idx     <= '0;
      flush_done <= 1'b0;
      for (int k = 0; k < K; k++) begin
        sum_q[k] <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      flush_done <= 1'b0;
      unique case (state_q)
        StAcc: begin
          // A saturated count freezes both the count and its sum.
          if (pt_valid && pt_ready && !cnt_full) begin
            sum_q[pt_label] <= sum_sat;
            cnt_q[pt_label] <= cnt_q[pt_label] + CW'(1);
          end
          if (pass_end) begin
            state_q  <= StConv;
            cl_idx   <= '0;
            pt_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        StConv: begin
          div_in1 <= to_fp16(16'(sum_q[cl_idx]));
          div_in2 <= to_fp16(16'(cnt_q[cl_idx]));
          if (cnt_q[cl_idx] == '0) begin
            state_q <= StNext;
          end else begin
            state_q <= StIssue;
            div_en  <= 1'b1;
          end
        end
        StIssue: begin
          if (div_done) begin
            div_en  <= 1'b0;
            state_q <= StNext;
          end
        end
        StNext: begin
          sum_q[cl_idx] <= '0;
          cnt_q[cl_idx] <= '0;
          if (cl_idx == LW'(K-1)) begin
            flush_done <= 1'b1;
            state_q    <= StAcc;
            cl_idx     <= '0;
            pt_ready   <= 1'b1;
            busy       <= 1'b0;
          end else begin
            cl_idx  <= cl_idx + LW'(1);
            state_q <= StConv;
          end
        end
        default: state_q <= StAcc;
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_accumulator.sv
// Self-checking bench for centroid_accumulator: behavioural accumulator/FP16 model,
// a latency-programmable divider stand-in, directed cases and randomized passes.
module tb_centroid_accumulator;
  localparam int K = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pt_valid, pt_ready, pass_end, div_en, div_done, busy, flush_done;
  logic [7:0]  pt_data;
  logic [1:0]  pt_label, cl_idx;
  logic [15:0] div_in1, div_in2;

  always #5 clk = ~clk;

  centroid_accumulator #(.K(4), .LW(2), .DW(8), .CW(8), .SW(16)) dut (
    .clk(clk), .rst(rst), .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .pt_label(pt_label), .pass_end(pass_end), .div_en(div_en), .div_in1(div_in1),
    .div_in2(div_in2), .div_done(div_done), .cl_idx(cl_idx), .busy(busy),
    .flush_done(flush_done)
  );

  typedef struct {
    int          cl;
    logic [15:0] a;
    logic [15:0] b;
  } iss_t;

  iss_t exp_q[$];
  iss_t log_q[$];
  iss_t cur;
  int   msum[K];
  int   mcnt[K];
  bit   flushing = 0;
  int   flushes = 0;
  int   checks = 0;
  int   failures = 0;
  int   lat = 1;
  int   dcnt;
  bit   prev_en = 0;
  int   en_cycles = 0;

  // Integer -> FP16 from plain arithmetic: value = 2^p * (1 + m/1024).
  function automatic logic [15:0] fp16_ref(input int v);
    int p, m;
    if (v == 0) return 16'h0000;
    p = 0;
    while ((v >> (p + 1)) != 0) p++;
`ifdef CONV_ROUND_EN
    m = ((v - (1 << p)) * 2048) >> p;
    m = (m + 1) / 2;
    if (m == 1024) begin
      m = 0;
      p++;
    end
`else
    m = ((v - (1 << p)) * 1024) >> p;
`endif
    return 16'(((p + 15) << 10) | m);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Divider stand-in: done rises after `lat` enabled cycles, clears when en drops.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_done <= 1'b0;
      dcnt     <= 0;
    end else if (!div_en) begin
      div_done <= 1'b0;
      dcnt     <= 0;
    end else begin
      dcnt <= dcnt + 1;
      if (dcnt + 1 >= lat) div_done <= 1'b1;
    end
  end

  // Reference model: accumulate accepted points, snapshot non-empty clusters on pass_end.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        if (pt_valid && !flushing && mcnt[pt_label] < 255) begin
          mcnt[pt_label]++;
          msum[pt_label] = (msum[pt_label] + int'(pt_data) > 65535) ? 65535
                                                                    : msum[pt_label] + int'(pt_data);
        end
        if (pass_end && !flushing) begin
          flushing = 1;
          for (int k = 0; k < K; k++) begin
            if (mcnt[k] != 0) exp_q.push_back('{k, fp16_ref(msum[k]), fp16_ref(mcnt[k])});
            msum[k] = 0;
            mcnt[k] = 0;
          end
        end
      end
    end
  end

  // Compare process, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en = 0;
      end else begin
        if (flush_done) begin
          chk("flush_done_when_flushing", 32'(flushing), 1);
          chk("flush_done_queue_empty", exp_q.size(), 0);
          flushing = 0;
          flushes++;
        end
        chk("pt_ready", 32'(pt_ready), 32'(!flushing));
        chk("busy", 32'(busy), 32'(flushing));
        if (div_en) begin
          if (!prev_en) begin
            en_cycles = 1;
            chk("issue_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
              cur = exp_q.pop_front();
              chk("cl_idx", 32'(cl_idx), cur.cl);
              chk("div_in1", 32'(div_in1), 32'(cur.a));
              chk("div_in2", 32'(div_in2), 32'(cur.b));
            end
            log_q.push_back('{int'(cl_idx), div_in1, div_in2});
          end else begin
            en_cycles++;
            chk("hold_cl_idx", 32'(cl_idx), cur.cl);
            chk("hold_div_in1", 32'(div_in1), 32'(cur.a));
            chk("hold_div_in2", 32'(div_in2), 32'(cur.b));
          end
        end else if (prev_en) begin
          chk("issue_cycles", en_cycles, lat + 1);
        end
        prev_en = div_en;
      end
    end
  end

  task automatic send(input int d, input int l);
    @(posedge clk); #1;
    pt_valid = 1'b1;
    pt_data  = 8'(d);
    pt_label = 2'(l);
  endtask

  // Pulse pass_end (optionally with a point in the same cycle), optionally offer
  // points during the first flush cycles, and wait for flush_done with a bound.
  task automatic do_pass(input bit with_pt, input int d, input int l, input bit junk);
    int f0, n;
    log_q.delete();
    f0 = flushes;
    @(posedge clk); #1;
    pass_end = 1'b1;
    pt_valid = with_pt;
    pt_data  = 8'(d);
    pt_label = 2'(l);
    @(posedge clk); #1;
    pass_end = 1'b0;
    pt_valid = junk;
    n = 0;
    while (flushes == f0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (junk) begin
        pt_data  = 8'($urandom);
        pt_label = 2'($urandom);
        if (n >= 3) pt_valid = 1'b0;
      end
    end
    pt_valid = 1'b0;
    chk("flush_timeout", 32'(flushes != f0), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("flush_count", flushes, f0 + 1);
  endtask

  initial begin
    int n, f0;
    pt_valid = 0; pt_data = 0; pt_label = 0; pass_end = 0;
    for (int k = 0; k < K; k++) begin
      msum[k] = 0;
      mcnt[k] = 0;
    end
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pt_ready", 32'(pt_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_div_en", 32'(div_en), 0);
    chk("rst_div_in1", 32'(div_in1), 0);
    chk("rst_div_in2", 32'(div_in2), 0);
    chk("rst_cl_idx", 32'(cl_idx), 0);
    chk("rst_flush_done", 32'(flush_done), 0);
    rst = 1'b0;

    // Three points into one cluster.
    send(10, 1); send(20, 1); send(30, 1);
    do_pass(0, 0, 0, 0);
    chk("t1_issues", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("t1_cl", log_q[0].cl, 1);
      chk("t1_in1", 32'(log_q[0].a), 32'h5380);
      chk("t1_in2", 32'(log_q[0].b), 32'h4200);
    end

    // Two clusters, issued in index order.
    send(4, 0); send(8, 3);
    do_pass(0, 0, 0, 0);
    chk("t2_issues", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t2_cl0", log_q[0].cl, 0);
      chk("t2_in1_0", 32'(log_q[0].a), 32'h4400);
      chk("t2_in2_0", 32'(log_q[0].b), 32'h3C00);
      chk("t2_cl1", log_q[1].cl, 3);
      chk("t2_in1_1", 32'(log_q[1].a), 32'h4800);
      chk("t2_in2_1", 32'(log_q[1].b), 32'h3C00);
    end

    // Slow divider; 4095 exercises the rounding boundary.
    lat = 5;
    for (int i = 0; i < 16; i++) send(255, 2);
    send(15, 2);
    do_pass(0, 0, 0, 0);
    chk("t3_issues", log_q.size(), 1);
    if (log_q.size() == 1) begin
`ifdef CONV_ROUND_EN
      chk("t3_in1", 32'(log_q[0].a), 32'h6C00);
`else
      chk("t3_in1", 32'(log_q[0].a), 32'h6BFF);
`endif
      chk("t3_in2", 32'(log_q[0].b), 32'h4C40);
    end
    lat = 1;

    // Count saturation freezes both sum and count.
    for (int i = 0; i < 300; i++) send(1, 0);
    do_pass(0, 0, 0, 0);
    chk("t4_issues", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("t4_in1", 32'(log_q[0].a), 32'h5BF8);
      chk("t4_in2", 32'(log_q[0].b), 32'h5BF8);
    end

    // Point alongside pass_end counts; points during flush do not.
    send(5, 2);
    do_pass(1, 7, 2, 1);
    chk("t5_issues", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("t5_in1", 32'(log_q[0].a), 32'h4A00);
      chk("t5_in2", 32'(log_q[0].b), 32'h4000);
    end
    do_pass(0, 0, 0, 0);
    chk("t5_empty_pass", log_q.size(), 0);

    // Reset while ISSUE is waiting on a slow divider.
    lat = 10;
    send(9, 1);
    @(posedge clk); #1;
    pt_valid = 1'b0;
    pass_end = 1'b1;
    @(posedge clk); #1;
    pass_end = 1'b0;
    n = 0;
    while (!div_en && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_issue_seen", 32'(div_en), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_div_en", 32'(div_en), 0);
    chk("t6_rst_pt_ready", 32'(pt_ready), 1);
    chk("t6_rst_busy", 32'(busy), 0);
    flushing = 0;
    exp_q.delete();
    for (int k = 0; k < K; k++) begin
      msum[k] = 0;
      mcnt[k] = 0;
    end
    f0 = flushes;
    @(posedge clk); #1;
    rst = 1'b0;
    lat = 1;
    chk("t6_no_flush_on_rst", flushes, f0);
    do_pass(0, 0, 0, 0);
    chk("t6_empty_pass", log_q.size(), 0);

    // Randomized passes against the model.
    for (int r = 0; r < 8; r++) begin
      lat = $urandom_range(1, 4);
      n = $urandom_range(0, 60);
      for (int i = 0; i < n; i++) begin
        @(posedge clk); #1;
        pt_valid = 1'($urandom);
        pt_data  = 8'($urandom);
        pt_label = 2'($urandom);
      end
      do_pass(1'($urandom), $urandom_range(0, 255), $urandom_range(0, 3), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
